// File: rtl/mlp_feature_driver.sv
// Sequencer around a combinational MLP classifier: collects one feature per beat,
// holds the packed vector for a settle window, then returns the captured result.
module mlp_feature_driver #(
  parameter int unsigned N_FEAT     = 16,
  parameter int unsigned FEAT_W     = 4,
  parameter int unsigned OUT_W      = 20,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_feat_valid,
  output logic                     s_feat_ready,
  input  logic [FEAT_W-1:0]        s_feat_data,
  input  logic                     s_feat_last,
  output logic [N_FEAT*FEAT_W-1:0] clf_inp,
  input  logic [OUT_W-1:0]         clf_out,
  output logic                     m_res_valid,
  input  logic                     m_res_ready,
  output logic [OUT_W-1:0]         m_res_data,
  output logic                     m_res_err,
  output logic                     busy
);

  localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned INP_W = N_FEAT * FEAT_W;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RESULT  = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_err_acc;
  logic               w_err_nxt;
  logic [INP_W-1:0]   r_clf_inp;
  logic               r_res_valid;
  logic [OUT_W-1:0]   r_res_data;
  logic               r_res_err;
  logic               r_feat_ready;
  logic               r_busy;
  logic               w_accept;
  logic               w_last_slot;
  logic               w_capture;
  logic               w_release;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err_acc;
    w_accept    = 1'b0;
    w_last_slot = (r_idx == IDX_W'(N_FEAT - 1));
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        w_accept = s_feat_valid;
        if (s_feat_valid) begin
          w_idx_nxt = r_idx + 1'b1;
          // Frame closes on the last slot or on an explicit last marker, whichever first
          if (w_last_slot || s_feat_last) begin
            w_idx_nxt   = '0;
            w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
            w_state_nxt = ST_SETTLE;
            if (!(w_last_slot && s_feat_last)) begin
              w_err_nxt = 1'b1;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESULT;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESULT: begin
        if (m_res_ready) begin
          w_release   = 1'b1;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_COLLECT;
        end
      end
      default: begin
        w_state_nxt = ST_COLLECT;
      end
    endcase
  end

  // Frame counters and error accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_err_acc <= 1'b0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err_acc <= w_err_nxt;
    end
  end

  // Classifier input vector: one slot written per accepted beat, cleared on result handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clf_inp <= '0;
    end else if (w_release) begin
      r_clf_inp <= '0;
    end else begin
      for (int i = 0; i < int'(N_FEAT); i++) begin
        if (w_accept && (r_idx == IDX_W'(i))) begin
          r_clf_inp[i*FEAT_W +: FEAT_W] <= s_feat_data;
        end
      end
    end
  end

  // Result holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_data  <= clf_out;
      r_res_err   <= r_err_acc;
    end else if (w_release) begin
      r_res_valid <= 1'b0;
    end
  end

  // Handshake status registered from the next state so it lines up with the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat_ready <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_feat_ready <= (w_state_nxt == ST_COLLECT);
      r_busy       <= (w_state_nxt != ST_COLLECT);
    end
  end

  assign s_feat_ready = r_feat_ready;
  assign clf_inp      = r_clf_inp;
  assign m_res_valid  = r_res_valid;
  assign m_res_data   = r_res_data;
  assign m_res_err    = r_res_err;
  assign busy         = r_busy;

endmodule
